// File: rtl/posit_serial_encoder_8bit_if.sv
// Handshake/bus bundle for the serial posit encoder: extended operand in, 8-bit posit out.
// POSIT_ENC_STATUS_EN adds the out_inexact/out_saturated status signals.
interface posit_serial_encoder_8bit_if;
  logic       in_valid;
  logic       in_ready;
  logic       p_inf;
  logic       p_zer;
  logic       p_sgn;
  logic [3:0] p_exp;
  logic [4:0] p_frc;
  logic [1:0] p_gs;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] posit;
`ifdef POSIT_ENC_STATUS_EN
  logic       out_inexact;
  logic       out_saturated;

  modport slave (
    input  in_valid, p_inf, p_zer, p_sgn, p_exp, p_frc, p_gs, out_ready,
    output in_ready, out_valid, posit, out_inexact, out_saturated
  );
  modport master (
    output in_valid, p_inf, p_zer, p_sgn, p_exp, p_frc, p_gs, out_ready,
    input  in_ready, out_valid, posit, out_inexact, out_saturated
  );
`else
  modport slave (
    input  in_valid, p_inf, p_zer, p_sgn, p_exp, p_frc, p_gs, out_ready,
    output in_ready, out_valid, posit
  );
  modport master (
    output in_valid, p_inf, p_zer, p_sgn, p_exp, p_frc, p_gs, out_ready,
    input  in_ready, out_valid, posit
  );
`endif
endinterface

// File: rtl/posit_serial_encoder_8bit.sv
// Multi-cycle es=0 posit encoder: regime built bitwise, fraction packed, then round-to-nearest-even.
// Optional status outputs (inexact/saturated) are enabled with POSIT_ENC_STATUS_EN.
module posit_serial_encoder_8bit #(
  parameter int FAST_SPECIAL = 1
) (
  input logic                          clk,
  input logic                          rst_n,
  posit_serial_encoder_8bit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, REGIME, PACK, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [4:0]  frc_q, frc_d;
  logic [1:0]  gs_q, gs_d;
  logic        run_q, run_d;
  logic [2:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stream_q, stream_d;
  logic [7:0]  posit_q, posit_d;
  logic        special_q, special_d;
`ifdef POSIT_ENC_STATUS_EN
  logic        inexact_q, inexact_d;
  logic        sat_q, sat_d;
`endif

  // Returns {clamp_fired, body} after applying the rounding increment and the two clamps.
  function automatic logic [7:0] round_body(input logic [6:0] body, input logic rnd);
    logic [7:0] sum;
    sum = {1'b0, body} + {7'b0, rnd};
    if (sum[7])               round_body = {1'b1, 7'h7F};
    else if (sum[6:0] == 7'd0) round_body = {1'b1, 7'h01};
    else                      round_body = {1'b0, sum[6:0]};
  endfunction

  function automatic logic [2:0] run_len(input logic signed [4:0] k);
    logic signed [4:0] r;
    r = k[4] ? -k : (k + 5'sd1);
    run_len = r[2:0];
  endfunction

  logic signed [4:0] k_s;
  logic [15:0]       tail_w;
  logic [6:0]        body_w;
  logic              g_w;
  logic              st_w;
  logic [7:0]        rb_w;

  assign k_s = $signed({1'b0, bus.p_exp}) - 5'sd7 + $signed({4'b0, bus.p_sgn});

  // With a full 7-bit run there is no terminator, so the fraction sits right after the run.
  assign tail_w = (r_q == 3'd7) ? ({frc_q, gs_q, 9'b0} >> 7)
                                : ({~run_q, frc_q, gs_q, 8'b0} >> r_q);
  assign body_w = stream_q[15:9];
  assign g_w    = stream_q[8];
  assign st_w   = (|stream_q[7:0]) | gs_q[0];
  assign rb_w   = round_body(body_w, g_w & (st_w | body_w[0]));

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    frc_d     = frc_q;
    gs_d      = gs_q;
    run_d     = run_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    stream_d  = stream_q;
    posit_d   = posit_q;
    special_d = special_q;
`ifdef POSIT_ENC_STATUS_EN
    inexact_d = inexact_q;
    sat_d     = sat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sgn_d    = bus.p_sgn;
          frc_d    = bus.p_frc;
          gs_d     = bus.p_gs;
          run_d    = ~k_s[4];
          r_d      = run_len(k_s);
          cnt_d    = run_len(k_s);
          stream_d = 16'd0;
`ifdef POSIT_ENC_STATUS_EN
          inexact_d = 1'b0;
          sat_d     = 1'b0;
`endif
          if (bus.p_inf || bus.p_zer) begin
            special_d = 1'b1;
            posit_d   = bus.p_inf ? 8'h80 : 8'h00;
            state_d   = (FAST_SPECIAL != 0) ? DONE : PACK;
          end else begin
            special_d = 1'b0;
            state_d   = REGIME;
          end
        end
      end
      REGIME: begin
        stream_d = {run_q, stream_q[15:1]};
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = PACK;
      end
      PACK: begin
        if (!special_q) stream_d = stream_q | tail_w;
        state_d = ROUND;
      end
      ROUND: begin
        if (!special_q) begin
          posit_d = {sgn_q, rb_w[6:0]};
`ifdef POSIT_ENC_STATUS_EN
          inexact_d = g_w | st_w;
          sat_d     = rb_w[7];
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      frc_q     <= 5'd0;
      gs_q      <= 2'd0;
      run_q     <= 1'b0;
      r_q       <= 3'd0;
      cnt_q     <= 3'd0;
      stream_q  <= 16'd0;
      posit_q   <= 8'h00;
      special_q <= 1'b0;
`ifdef POSIT_ENC_STATUS_EN
      inexact_q <= 1'b0;
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      frc_q     <= frc_d;
      gs_q      <= gs_d;
      run_q     <= run_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      stream_q  <= stream_d;
      posit_q   <= posit_d;
      special_q <= special_d;
`ifdef POSIT_ENC_STATUS_EN
      inexact_q <= inexact_d;
      sat_q     <= sat_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.posit     = posit_q;
`ifdef POSIT_ENC_STATUS_EN
  assign bus.out_inexact   = inexact_q;
  assign bus.out_saturated = sat_q;
`endif

endmodule

// File: tb/tb_posit_serial_encoder_8bit.sv
// Bench for posit_serial_encoder_8bit: directed vector table, handshake/reset sequences, random vs model.
module tb_posit_serial_encoder_8bit;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  posit_serial_encoder_8bit_if bif();

  posit_serial_encoder_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         inf;
    bit         zer;
    bit         sgn;
    logic [3:0] ex;
    logic [4:0] fr;
    logic [1:0] gs;
    logic [7:0] ep;
    int         lat;
    bit         inx;
    bit         sat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: posit bit string assembled from the regime/fraction rules, then RNE on integers.
  function automatic void model(input bit inf, input bit zer, input bit sgn,
                                input logic [3:0] ex, input logic [4:0] fr, input logic [1:0] gs,
                                output logic [7:0] p, output int lat, output bit inx, output bit sat);
    bit q[$];
    int k, r, b;
    bit g, st;
    if (inf || zer) begin
      p = inf ? 8'h80 : 8'h00;
      lat = 0; inx = 0; sat = 0;
      return;
    end
    k = int'(ex) - 7 + int'(sgn);
    r = (k >= 0) ? k + 1 : -k;
    for (int i = 0; i < r; i++) q.push_back(k >= 0);
    if (r < 7) q.push_back(k < 0);
    for (int i = 4; i >= 0; i--) q.push_back(fr[i]);
    q.push_back(gs[1]);
    q.push_back(gs[0]);
    while (q.size() < 16) q.push_back(1'b0);
    b = 0;
    for (int i = 0; i < 7; i++) b = b * 2 + int'(q[i]);
    g  = q[7];
    st = gs[0];
    for (int i = 8; i < 16; i++) st = st | q[i];
    inx = g | st;
    sat = 0;
    if (g && (st || (b % 2 == 1))) b = b + 1;
    if (b == 128) begin b = 127; sat = 1; end
    else if (b == 0) begin b = 1; sat = 1; end
    p = 8'(b) | (sgn ? 8'h80 : 8'h00);
    lat = r + 2;
  endfunction

  task automatic drive_in(input bit inf, input bit zer, input bit sgn,
                          input logic [3:0] ex, input logic [4:0] fr, input logic [1:0] gs);
    bif.p_inf = inf; bif.p_zer = zer; bif.p_sgn = sgn;
    bif.p_exp = ex;  bif.p_frc = fr;  bif.p_gs  = gs;
  endtask

  task automatic scramble_in();
    drive_in(1'b0, 1'b0, 1'($urandom), 4'($urandom), 5'($urandom), 2'($urandom));
  endtask

  // Waits (bounded) for out_valid at negedges; returns negedges elapsed after the accepting edge.
  task automatic wait_valid(output int lat);
    @(negedge clk);
    lat = 0;
    while (!bif.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge; leaves at a negedge with the encoder back in IDLE.
  task automatic run_op(input string nm, input bit inf, input bit zer, input bit sgn,
                        input logic [3:0] ex, input logic [4:0] fr, input logic [1:0] gs,
                        input logic [7:0] ep, input int elat, input bit einx, input bit esat,
                        input int stall);
    int lat, w;
    w = 0;
    while (!bif.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_in_ready"}, int'(bif.in_ready), 1);
    drive_in(inf, zer, sgn, ex, fr, gs);
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    scramble_in();
    wait_valid(lat);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_posit"}, int'(bif.posit), int'(ep));
`ifdef POSIT_ENC_STATUS_EN
    chk({nm, "_inexact"}, int'(bif.out_inexact), int'(einx));
    chk({nm, "_saturated"}, int'(bif.out_saturated), int'(esat));
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, int'(bif.out_valid), 1);
      chk({nm, "_hold_posit"}, int'(bif.posit), int'(ep));
    end
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_valid_drop"}, int'(bif.out_valid), 0);
    chk({nm, "_back_idle"}, int'(bif.in_ready), 1);
  endtask

  initial begin
    int          lat;
    logic [7:0]  ep;
    int          elat;
    bit          einx, esat;
    bit          inf, zer, sgn;
    int          k;
    logic [3:0]  ex;
    logic [4:0]  fr;
    logic [1:0]  gs;

    vt[0]  = '{"plus_one",  0, 0, 0, 4'd7,  5'b00000, 2'b00, 8'h40, 3, 0, 0};
    vt[1]  = '{"k2_round",  0, 0, 0, 4'd9,  5'b10110, 2'b11, 8'h76, 5, 1, 0};
    vt[2]  = '{"k6_sat",    0, 0, 0, 4'd13, 5'b11111, 2'b11, 8'h7F, 9, 1, 1};
    vt[3]  = '{"minus_one", 0, 0, 1, 4'd6,  5'b00000, 2'b00, 8'hC0, 3, 0, 0};
    vt[4]  = '{"inf",       1, 0, 0, 4'd0,  5'b00000, 2'b00, 8'h80, 0, 0, 0};
    vt[5]  = '{"zero",      0, 1, 0, 4'd0,  5'b00000, 2'b00, 8'h00, 0, 0, 0};
    vt[6]  = '{"nan",       1, 1, 1, 4'd5,  5'b10101, 2'b01, 8'h80, 0, 0, 0};
    vt[7]  = '{"kmin",      0, 0, 0, 4'd1,  5'b00000, 2'b00, 8'h01, 8, 0, 0};
    vt[8]  = '{"tie_even",  0, 0, 0, 4'd7,  5'b00000, 2'b10, 8'h40, 3, 1, 0};
    vt[9]  = '{"tie_odd",   0, 0, 0, 4'd7,  5'b00001, 2'b10, 8'h42, 3, 1, 0};
    vt[10] = '{"neg_k2",    0, 0, 1, 4'd8,  5'b01010, 2'b10, 8'hF3, 5, 1, 0};
    vt[11] = '{"carry_k",   0, 0, 0, 4'd6,  5'b11111, 2'b11, 8'h40, 3, 1, 0};

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    drive_in(0, 0, 0, 4'd0, 5'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(bif.in_ready), 1);
    chk("reset_out_valid", int'(bif.out_valid), 0);
    chk("reset_posit", int'(bif.posit), 0);
`ifdef POSIT_ENC_STATUS_EN
    chk("reset_inexact", int'(bif.out_inexact), 0);
    chk("reset_saturated", int'(bif.out_saturated), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(vt[i].nm, vt[i].inf, vt[i].zer, vt[i].sgn, vt[i].ex, vt[i].fr, vt[i].gs,
             vt[i].ep, vt[i].lat, vt[i].inx, vt[i].sat, i % 3);

    // Backpressure: result held, new operand ignored until the encoder is back in IDLE.
    drive_in(0, 0, 0, 4'd7, 5'b00000, 2'b00);
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive_in(0, 0, 0, 4'd9, 5'b10110, 2'b11);
    wait_valid(lat);
    chk("bp_first_latency", lat, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(bif.out_valid), 1);
      chk("bp_hold_posit", int'(bif.posit), 8'h40);
      chk("bp_in_ready_low", int'(bif.in_ready), 0);
    end
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", int'(bif.in_ready), 1);
    chk("bp_idle_valid", int'(bif.out_valid), 0);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_second_latency", lat, 5);
    chk("bp_second_posit", int'(bif.posit), 8'h76);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a long regime build.
    drive_in(0, 0, 0, 4'd13, 5'b11111, 2'b11);
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pre_in_ready", int'(bif.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bif.out_valid), 0);
    chk("rst_posit", int'(bif.posit), 0);
    chk("rst_in_ready", int'(bif.in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 0, 0, 0, 4'd7, 5'b00000, 2'b00, 8'h40, 3, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      inf = ($urandom_range(0, 9) == 0);
      zer = ($urandom_range(0, 9) == 0);
      sgn = 1'($urandom);
      k   = int'($urandom_range(0, 12)) - 6;
      ex  = 4'(k + 7 - int'(sgn));
      fr  = 5'($urandom);
      gs  = 2'($urandom);
      model(inf, zer, sgn, ex, fr, gs, ep, elat, einx, esat);
      run_op("random", inf, zer, sgn, ex, fr, gs, ep, elat, einx, esat, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
